// File: rtl/dll_code_ctrl.sv
// DLL delay-code controller: SAR coarse search, +/-1 tracking with reversal lock, harmonic recovery.
// Decisions every SETTLE+1 clocks; no backpressure. Define DLL_CODE_SYNC_EN to add 2-flop input synchronizers.
module dll_code_ctrl #(
  parameter int WIDTH    = 10,
  parameter int SETTLE   = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic             en,
  input  logic             pd_up,
  input  logic             hld1,
  input  logic             hld2,
  output logic [WIDTH-1:0] Q,
  output logic             Sel,
  output logic             lock,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAR     = 2'd1,
    TRACK   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] Q_RST  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX  = '1;
  localparam logic [3:0]     SETTLE_L = 4'(SETTLE);
  localparam logic [3:0]     LOCK_L   = 4'(LOCK_CNT);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [3:0]       cnt;
  logic [3:0]       rev;
  logic             last_up;
  logic             dir_vld;

  logic             pd_s;
  logic             h1_s;
  logic             h2_s;

`ifdef DLL_CODE_SYNC_EN
  logic [1:0] pd_ff;
  logic [1:0] h1_ff;
  logic [1:0] h2_ff;

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      pd_ff <= '0;
      h1_ff <= '0;
      h2_ff <= '0;
    end else begin
      pd_ff <= {pd_ff[0], pd_up};
      h1_ff <= {h1_ff[0], hld1};
      h2_ff <= {h2_ff[0], hld2};
    end
  end

  assign pd_s = pd_ff[1];
  assign h1_s = h1_ff[1];
  assign h2_s = h2_ff[1];
`else
  assign pd_s = pd_up;
  assign h1_s = hld1;
  assign h2_s = hld2;
`endif

  logic [WIDTH:0]   q_grow;
  logic [WIDTH-1:0] q_hld2;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] sar_q;
  logic [3:0]       rev_nxt;

  assign q_grow = {1'b0, Q} + {2'b00, Q[WIDTH-1:1]};
  assign q_hld2 = q_grow[WIDTH] ? Q_MAX : q_grow[WIDTH-1:0];
  assign q_inc  = (Q == Q_MAX) ? Q : Q + WIDTH'(1);
  assign q_dec  = (Q == '0)    ? Q : Q - WIDTH'(1);

  // Trial bit takes the PD verdict; the next lower bit becomes the new trial.
  always_comb begin
    sar_q      = Q;
    sar_q[idx] = pd_s;
    if (idx != '0) sar_q[idx - IW'(1)] = 1'b1;
  end

  // First step after entering TRACK has no prior direction, so it neither counts nor clears.
  always_comb begin
    rev_nxt = '0;
    if (dir_vld && (pd_s != last_up)) rev_nxt = (rev == LOCK_L) ? rev : rev + 4'd1;
  end

  always_ff @(posedge clk_ext) begin
    if (rst || !en) begin
      state   <= IDLE;
      Q       <= Q_RST;
      Sel     <= 1'b0;
      lock    <= 1'b0;
      cnt     <= SETTLE_L;
      idx     <= IDX_TOP;
      rev     <= '0;
      last_up <= 1'b0;
      dir_vld <= 1'b0;
    end else begin
      Sel <= 1'b0;
      case (state)
        IDLE: begin
          state <= SAR;
          cnt   <= SETTLE_L;
        end
        SAR, TRACK: begin
          if (h1_s || h2_s) begin
            Q     <= h1_s ? {1'b0, Q[WIDTH-1:1]} : q_hld2;
            Sel   <= 1'b1;
            lock  <= 1'b0;
            rev   <= '0;
            cnt   <= SETTLE_L;
            state <= RECOVER;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            cnt <= SETTLE_L;
            Sel <= 1'b1;
            if (state == SAR) begin
              Q <= sar_q;
              if (idx == '0) begin
                state   <= TRACK;
                rev     <= '0;
                dir_vld <= 1'b0;
              end else begin
                idx <= idx - IW'(1);
              end
            end else begin
              Q       <= pd_s ? q_inc : q_dec;
              last_up <= pd_s;
              dir_vld <= 1'b1;
              rev     <= rev_nxt;
              lock    <= (rev_nxt == LOCK_L);
            end
          end
        end
        RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= TRACK;
            cnt     <= SETTLE_L;
            dir_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule
